// File: rtl/time_counter_if.sv
// Button/time bus of the clock core.
//   btn_mode, btn_inc : 1-cycle pulses toward the core
//   sec_o, min_o      : binary 0-59
//   hour_o            : binary 0-23
//   mode_o            : 00 RUN, 01 SET_MIN, 10 SET_HOUR
//   sec_tick          : 1-cycle pulse on each RUN seconds update
interface time_counter_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [5:0] sec_o;
  logic [5:0] min_o;
  logic [4:0] hour_o;
  logic [1:0] mode_o;
  logic       sec_tick;

  modport master (output btn_mode, btn_inc,
                  input  sec_o, min_o, hour_o, mode_o, sec_tick);
  modport slave  (input  btn_mode, btn_inc,
                  output sec_o, min_o, hour_o, mode_o, sec_tick);
endinterface

// File: rtl/time_counter.sv
// Timekeeping core: divides clk to a 1 Hz tick, keeps binary sec/min/hour,
// and lets the user adjust minutes and hours through a 3-state set FSM.
//   clk    : system clock, posedge
//   reset_ : asynchronous active-high reset
//   bus    : slave side of time_counter_if (buttons in, time/mode/tick out)
// All outputs are registered.
module time_counter #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int PRESC_W = 26
) (
  input  logic    clk,
  input  logic    reset_,
  time_counter_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_MIN  = 2'b01,
    SET_HOUR = 2'b10,
    ILLEGAL  = 2'b11
  } state_t;

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);

  state_t             state, state_n;
  logic [PRESC_W-1:0] presc, presc_n;
  logic [5:0]         sec, sec_n, min, min_n;
  logic [4:0]         hour, hour_n;
  logic               tick, tick_n;

  // Field increments: out-of-range values (>= max) fall back to 0; carry
  // only propagates from an exact max so a corrupted field cannot ripple.
  logic [5:0] sec_inc, min_inc;
  logic [4:0] hour_inc;
  logic       sec_cy, min_cy;

  assign sec_inc  = (sec  >= 6'd59) ? 6'd0 : sec  + 6'd1;
  assign min_inc  = (min  >= 6'd59) ? 6'd0 : min  + 6'd1;
  assign hour_inc = (hour >= 5'd23) ? 5'd0 : hour + 5'd1;
  assign sec_cy   = (sec == 6'd59);
  assign min_cy   = (min == 6'd59);

  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      state <= RUN;
      presc <= '0;
      sec   <= '0;
      min   <= '0;
      hour  <= '0;
      tick  <= 1'b0;
    end else begin
      state <= state_n;
      presc <= presc_n;
      sec   <= sec_n;
      min   <= min_n;
      hour  <= hour_n;
      tick  <= tick_n;
    end
  end

  always_comb begin
    state_n = state;
    presc_n = '0;
    sec_n   = sec;
    min_n   = min;
    hour_n  = hour;
    tick_n  = 1'b0;
    unique case (state)
      RUN: begin
        if (bus.btn_mode) begin
          // Leaving RUN discards any tick due on this edge.
          state_n = SET_MIN;
        end else if (presc >= PRESC_MAX) begin
          tick_n = 1'b1;
          sec_n  = sec_inc;
          if (sec_cy) begin
            min_n = min_inc;
            if (min_cy) hour_n = hour_inc;
          end
        end else begin
          presc_n = presc + 1'b1;
        end
      end
      SET_MIN: begin
        if (bus.btn_mode)     state_n = SET_HOUR;
        else if (bus.btn_inc) min_n   = min_inc;
      end
      SET_HOUR: begin
        if (bus.btn_mode) begin
          state_n = RUN;
          sec_n   = '0;
        end else if (bus.btn_inc) begin
          hour_n = hour_inc;
        end
      end
      default: state_n = RUN;
    endcase
  end

  assign bus.sec_o    = sec;
  assign bus.min_o    = min;
  assign bus.hour_o   = hour;
  assign bus.mode_o   = state;
  assign bus.sec_tick = tick;

endmodule
